// File: rtl/vga_cube_pkg.sv
// Shared vga_cube definitions: framebuffer widths, rasteriser state encoding
// and the coordinate/colour types used on the framebuffer write path.
package vga_cube_pkg;
    localparam int CORDW  = 10;
    localparam int COLORW = 3;

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

    typedef logic [CORDW-1:0]  coord_t;
    typedef logic [COLORW-1:0] color_t;
endpackage

// File: rtl/line_drawer_if.sv
// Request/pixel bundle between the cube renderer (master) and line_drawer (slave).
interface line_drawer_if #(
    parameter int CORDW  = vga_cube_pkg::CORDW,
    parameter int COLORW = vga_cube_pkg::COLORW
);
    // Handshake: start is a request pulse sampled only while the drawer is idle;
    // endpoints/colour are captured on that cycle. busy covers the whole request.
    // oe=0 stalls emission; each cycle with we=1 carries exactly one pixel, and
    // done rides on the last pixel's we.
    logic              start;
    logic              oe;
    logic [CORDW-1:0]  x0, y0, x1, y1;
    logic [COLORW-1:0] color_in;
    logic              busy, done, we;
    logic [CORDW-1:0]  x, y;
    logic [COLORW-1:0] color;

    modport slave (
        input  start, oe, x0, y0, x1, y1, color_in,
        output busy, done, we, x, y, color
    );
    modport master (
        output start, oe, x0, y0, x1, y1, color_in,
        input  busy, done, we, x, y, color
    );
endinterface

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: one segment per start, one framebuffer write per
// pixel with registered we/x/y/color.
module line_drawer #(
    parameter int CORDW  = vga_cube_pkg::CORDW,
    parameter int COLORW = vga_cube_pkg::COLORW
) (
    input  logic                 clk,
    input  logic                 rst,
    line_drawer_if.slave         bus,
    output vga_cube_pkg::state_t state_dbg
);
    import vga_cube_pkg::*;

    localparam int EW = CORDW + 2;
    typedef logic signed [EW-1:0] err_t;

    state_t            state, state_next;
    logic [CORDW-1:0]  lx0, ly0, lx1, ly1, cur_x, cur_y;
    logic [COLORW-1:0] lcolor;
    logic [CORDW-1:0]  adx, ady;
    err_t              dx, dy, err, e2, err_step;
    logic              sx_pos, sy_pos, step_x, step_y, at_end;

    assign state_dbg = state;

    always_comb begin
        adx      = (lx1 >= lx0) ? lx1 - lx0 : lx0 - lx1;
        ady      = (ly1 >= ly0) ? ly1 - ly0 : ly0 - ly1;
        e2       = err <<< 1;
        step_x   = (e2 >= dy);
        step_y   = (e2 <= dx);
        err_step = err + (step_x ? dy : err_t'(0)) + (step_y ? dx : err_t'(0));
        at_end   = (cur_x == lx1) && (cur_y == ly1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = INIT;
            INIT:    state_next = DRAW;
            DRAW:    if (bus.oe && at_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.we    <= 1'b0;
            bus.x     <= '0;
            bus.y     <= '0;
            bus.color <= '0;
            lx0 <= '0; ly0 <= '0; lx1 <= '0; ly1 <= '0; lcolor <= '0;
            cur_x <= '0; cur_y <= '0;
            dx <= '0; dy <= '0; err <= '0;
            sx_pos <= 1'b0; sy_pos <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.we   <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    lx0 <= bus.x0; ly0 <= bus.y0;
                    lx1 <= bus.x1; ly1 <= bus.y1;
                    lcolor   <= bus.color_in;
                    bus.busy <= 1'b1;
                end
                INIT: begin
                    dx     <= $signed({2'b00, adx});
                    dy     <= -$signed({2'b00, ady});
                    err    <= $signed({2'b00, adx}) - $signed({2'b00, ady});
                    sx_pos <= (lx0 < lx1);
                    sy_pos <= (ly0 < ly1);
                    cur_x  <= lx0;
                    cur_y  <= ly0;
                end
                DRAW: if (bus.oe) begin
                    bus.we    <= 1'b1;
                    bus.x     <= cur_x;
                    bus.y     <= cur_y;
                    bus.color <= lcolor;
                    if (at_end) begin
                        bus.done <= 1'b1;
                    end else begin
                        // Both axes may step in one cycle; err_step already sums both terms.
                        err <= err_step;
                        if (step_x) cur_x <= sx_pos ? cur_x + CORDW'(1) : cur_x - CORDW'(1);
                        if (step_y) cur_y <= sy_pos ? cur_y + CORDW'(1) : cur_y - CORDW'(1);
                    end
                end
                DONE: bus.busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_drawer.sv
// Self-checking bench for line_drawer: directed lines, stalls, reset abort and
// random segments against a pixel-list reference model.
module tb_line_drawer;
  import vga_cube_pkg::*;

  logic clk = 1'b0;
  logic rst;
  state_t state_dbg;
  int n_cmp = 0;
  int n_err = 0;
  logic [CORDW+CORDW+COLORW-1:0] exp_q[$];

  line_drawer_if ld_if();

  line_drawer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ld_if),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list of pixels from the integer Bresenham rule, plus colour.
  function automatic void ref_line(input int x0, input int y0, input int x1, input int y1,
                                   input int c);
    int dx, dy, sx, sy, err, e2, px, py;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    px = x0;
    py = y0;
    forever begin
      exp_q.push_back({CORDW'(px), CORDW'(py), COLORW'(c)});
      if (px == x1 && py == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; px += sx; end
      if (e2 <= dx) begin err += dx; py += sy; end
    end
  endfunction

  // Runs one segment from a negedge; returns at a negedge.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1, input int c,
                          input int stall_at, input int stall_len, input bit poke,
                          input int rst_after);
    int cyc, got, first, stall_left, npix;
    bit fin;
    exp_q.delete();
    ref_line(x0, y0, x1, y1, c);
    npix = ((x1 > x0 ? x1 - x0 : x0 - x1) > (y1 > y0 ? y1 - y0 : y0 - y1)) ?
           (x1 > x0 ? x1 - x0 : x0 - x1) + 1 : (y1 > y0 ? y1 - y0 : y0 - y1) + 1;
    ld_if.x0 = CORDW'(x0); ld_if.y0 = CORDW'(y0);
    ld_if.x1 = CORDW'(x1); ld_if.y1 = CORDW'(y1);
    ld_if.color_in = COLORW'(c);
    ld_if.start = 1'b1;
    @(negedge clk);
    ld_if.start = 1'b0;
    cyc = 1; got = 0; first = -1; stall_left = 0; fin = 1'b0;
    chk("busy_after_start", ld_if.busy, 1);
    while (!fin && cyc < 2200) begin
      if (stall_left > 0) begin
        chk("we_in_stall", ld_if.we, 0);
        stall_left--;
        if (stall_left == 0) ld_if.oe = 1'b1;
      end else if (ld_if.we) begin
        if (got == 0) chk("first_we_cycle", cyc, 3);
        if (exp_q.size() == 0) chk("extra_pixel", 1, 0);
        else chk("pixel", {ld_if.x, ld_if.y, ld_if.color}, exp_q.pop_front());
        got++;
        chk("done_flag", ld_if.done, exp_q.size() == 0);
        if (ld_if.done) begin
          chk("busy_at_done", ld_if.busy, 1);
          fin = 1'b1;
        end
        if (got == stall_at && stall_len > 0) begin
          ld_if.oe = 1'b0;
          stall_left = stall_len;
        end
        if (rst_after > 0 && got == rst_after) begin
          rst = 1'b1;
          @(negedge clk);
          chk("rst_we", ld_if.we, 0);
          chk("rst_busy", ld_if.busy, 0);
          chk("rst_x", ld_if.x, 0);
          chk("rst_y", ld_if.y, 0);
          chk("rst_state", state_dbg, IDLE);
          rst = 1'b0;
          return;
        end
      end
      if (poke) begin
        ld_if.start = (cyc == 5);
        ld_if.x0 = CORDW'(7); ld_if.y0 = CORDW'(7);
        ld_if.x1 = CORDW'(9); ld_if.y1 = CORDW'(9);
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    ld_if.start = 1'b0;
    ld_if.oe = 1'b1;
    chk("line_finished", fin, 1);
    chk("pixel_count", got, npix);
    @(negedge clk);
    chk("we_after_done", ld_if.we, 0);
    chk("done_pulse_len", ld_if.done, 0);
    @(negedge clk);
    chk("busy_low", ld_if.busy, 0);
    chk("idle_after", state_dbg, IDLE);
  endtask

  initial begin
    rst = 1'b1;
    ld_if.start = 1'b0; ld_if.oe = 1'b1;
    ld_if.x0 = '0; ld_if.y0 = '0; ld_if.x1 = '0; ld_if.y1 = '0; ld_if.color_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", ld_if.busy, 0);
    chk("reset_done", ld_if.done, 0);
    chk("reset_we", ld_if.we, 0);
    chk("reset_xy", {ld_if.x, ld_if.y}, 0);
    chk("reset_color", ld_if.color, 0);
    chk("reset_state", state_dbg, IDLE);
    rst = 1'b0;
    @(negedge clk);

    run_line(0, 0, 4, 0, 5, 0, 0, 1'b0, 0);
    run_line(6, 6, 2, 2, 2, 0, 0, 1'b0, 0);
    run_line(1, 0, 2, 5, 7, 0, 0, 1'b0, 0);
    run_line(3, 3, 3, 3, 1, 0, 0, 1'b0, 0);
    run_line(0, 0, 4, 0, 6, 2, 3, 1'b1, 0);
    run_line(0, 0, 9, 0, 4, 0, 0, 1'b0, 2);
    run_line(1, 1, 1, 3, 3, 0, 0, 1'b0, 0);
    run_line(1023, 0, 0, 1023, 7, 0, 0, 1'b0, 0);

    for (int i = 0; i < 8; i++)
      run_line($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(1, 4),
               $urandom_range(0, 3), 1'b1, 0);
    for (int i = 0; i < 6; i++)
      run_line($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 1023), $urandom_range(0, 7), $urandom_range(1, 40),
               $urandom_range(0, 5), 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
